// File: rtl/icache_direct_pkg.sv
// rtl/icache_direct_pkg.sv - shared word width and FSM encodings for the instruction cache
package icache_direct_pkg;
  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_FILL = 2'd1,
    IC_DONE = 2'd2
  } ic_state_e;
endpackage

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - valid/tag/data arrays with combinational read and whole-line write
module icache_line_store #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4,
  parameter int IDX_W      = 2,
  parameter int TAG_W      = 12
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [IDX_W-1:0]                     rd_index,
  output logic                                 rd_valid,
  output logic [TAG_W-1:0]                     rd_tag,
  output logic [LINE_WORDS-1:0][WORD_SIZE-1:0] rd_line,
  input  logic                                 wr_en,
  input  logic [IDX_W-1:0]                     wr_index,
  input  logic [TAG_W-1:0]                     wr_tag,
  input  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] wr_line
);
  logic [NUM_LINES-1:0]                 valid_q, valid_d;
  logic [TAG_W-1:0]                     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]                     tag_d  [NUM_LINES];
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] data_q [NUM_LINES];
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] data_d [NUM_LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = wr_tag;
      data_d[wr_index]  = wr_line;
    end
  end

  // Only the valid bits are reset; stale tags/data are unreachable while invalid.
  always_ff @(posedge clk) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];
endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with line refill FSM
module icache_direct #(
  parameter int WORD_SIZE  = icache_direct_pkg::WORD_SIZE,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             cpu_read,
  input  logic [WORD_SIZE-1:0]             cpu_addr,
  output logic [WORD_SIZE-1:0]             cpu_data,
  output logic                             cpu_ready,
  output logic                             mem_read,
  output logic [WORD_SIZE-1:0]             mem_addr,
  input  logic [LINE_WORDS*WORD_SIZE-1:0]  mem_line,
  input  logic                             mem_valid,
  output logic [WORD_SIZE-1:0]             hit_count,
  output logic [WORD_SIZE-1:0]             miss_count
);
  import icache_direct_pkg::*;

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

  ic_state_e            state_q, state_d;
  logic [WORD_SIZE-1:0] fill_addr_q, fill_addr_d;
  logic [WORD_SIZE-1:0] hit_count_q, hit_count_d;
  logic [WORD_SIZE-1:0] miss_count_q, miss_count_d;

  logic [OFF_W-1:0]                     offset;
  logic [IDX_W-1:0]                     index;
  logic [TAG_W-1:0]                     tag;
  logic                                 rd_valid;
  logic [TAG_W-1:0]                     rd_tag;
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] rd_line;
  logic                                 line_wr;
  logic                                 hit;

  assign offset = cpu_addr[OFF_W-1:0];
  assign index  = cpu_addr[OFF_W +: IDX_W];
  assign tag    = cpu_addr[WORD_SIZE-1 -: TAG_W];

  // The write index/tag come from the latched address so fetch-address changes mid-fill are harmless.
  assign line_wr = (state_q == IC_FILL) && mem_valid;

  icache_line_store #(
    .WORD_SIZE (WORD_SIZE),
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_index(index),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_line (rd_line),
    .wr_en   (line_wr),
    .wr_index(fill_addr_q[OFF_W +: IDX_W]),
    .wr_tag  (fill_addr_q[WORD_SIZE-1 -: TAG_W]),
    .wr_line (mem_line)
  );

  assign hit = cpu_read && rd_valid && (rd_tag == tag) && (state_q == IC_IDLE);

  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    case (state_q)
      IC_IDLE: begin
        if (cpu_read && hit) begin
          hit_count_d = hit_count_q + 1'b1;
        end else if (cpu_read) begin
          fill_addr_d  = {cpu_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
          miss_count_d = miss_count_q + 1'b1;
          state_d      = IC_FILL;
        end
      end
      IC_FILL: if (mem_valid) state_d = IC_DONE;
      IC_DONE: state_d = IC_IDLE;
      default: state_d = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IC_IDLE;
      fill_addr_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign cpu_ready  = hit;
  assign cpu_data   = hit ? rd_line[offset] : '0;
  assign mem_read   = (state_q == IC_FILL);
  assign mem_addr   = mem_read ? fill_addr_q : '0;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - directed self-checking bench for icache_direct
module tb_icache_direct;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_read;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_ready;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic [63:0] mem_line;
  logic        mem_valid;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  icache_direct dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_read  (cpu_read),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_ready (cpu_ready),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_line  (mem_line),
    .mem_valid (mem_valid),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word k of the line at base b is b + 0x1111*(k+1); base 0 gives 1111,2222,3333,4444.
  function automatic logic [63:0] make_line(input logic [15:0] base);
    logic [63:0] l;
    for (int k = 0; k < 4; k++) l[k*16 +: 16] = 16'(base + 16'h1111 * 16'(k + 1));
    return l;
  endfunction

  task automatic do_miss(input logic [15:0] addr, input int m);
    cpu_read = 1'b1;
    cpu_addr = addr;
    #1;
    check("miss_ready", 16'(cpu_ready), 16'd0);
    check("miss_data", cpu_data, 16'h0000);
    step();
    for (int i = 0; i < m; i++) begin
      check("fill_rd", 16'(mem_read), 16'd1);
      check("fill_addr", mem_addr, addr);
      step();
    end
    check("fill_rd_last", 16'(mem_read), 16'd1);
    check("fill_addr_last", mem_addr, addr);
    mem_line  = make_line(addr);
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    mem_line  = '0;
    check("done_ready", 16'(cpu_ready), 16'd0);
    check("done_rd", 16'(mem_read), 16'd0);
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    cpu_read  = 1'b0;
    cpu_addr  = '0;
    mem_line  = '0;
    mem_valid = 1'b0;
    step();
    step();
    check("rst_ready", 16'(cpu_ready), 16'd0);
    check("rst_data", cpu_data, 16'h0000);
    check("rst_rd", 16'(mem_read), 16'd0);
    check("rst_maddr", mem_addr, 16'h0000);
    check("rst_hits", hit_count, 16'd0);
    check("rst_miss", miss_count, 16'd0);
    reset_n = 1'b1;

    // cold miss, M=2
    do_miss(16'h0000, 2);
    check("cold_ready", 16'(cpu_ready), 16'd1);
    check("cold_data", cpu_data, 16'h1111);
    check("cold_miss", miss_count, 16'd1);
    step();

    // spatial hits
    for (int a = 1; a < 4; a++) begin
      cpu_addr = 16'(a);
      #1;
      check("sp_ready", 16'(cpu_ready), 16'd1);
      check("sp_data", cpu_data, 16'(16'h1111 * 16'(a + 1)));
      step();
    end
    check("sp_hits", hit_count, 16'd4);

    // conflict eviction, then re-miss with M=0
    do_miss(16'h0010, 1);
    check("cf_data", cpu_data, 16'h1121);
    do_miss(16'h0000, 0);
    check("cf_miss", miss_count, 16'd3);
    check("cf_data0", cpu_data, 16'h1111);

    // address change mid-fill
    cpu_addr = 16'h0004;
    #1;
    check("mc_ready", 16'(cpu_ready), 16'd0);
    step();
    check("mc_addr0", mem_addr, 16'h0004);
    cpu_addr = 16'h0008;
    step();
    check("mc_rd1", 16'(mem_read), 16'd1);
    check("mc_addr1", mem_addr, 16'h0004);
    mem_line  = make_line(16'h0004);
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    check("mc_done", 16'(cpu_ready), 16'd0);
    step();
    do_miss(16'h0008, 1);
    check("mc_data8", cpu_data, 16'h1119);
    cpu_addr = 16'h0004;
    #1;
    check("mc_data4", cpu_data, 16'h1115);
    cpu_addr = 16'h0005;
    #1;
    check("mc_data5", cpu_data, 16'h2226);

    // spurious mem_valid in IDLE
    cpu_read  = 1'b0;
    mem_line  = {4{16'hDEAD}};
    mem_valid = 1'b1;
    #1;
    check("sv_ready", 16'(cpu_ready), 16'd0);
    check("sv_data", cpu_data, 16'h0000);
    step();
    mem_valid = 1'b0;
    mem_line  = '0;
    check("sv_hits", hit_count, 16'd4);
    check("sv_miss", miss_count, 16'd5);
    cpu_read = 1'b1;
    cpu_addr = 16'h0004;
    #1;
    check("sv_data4", cpu_data, 16'h1115);
    cpu_addr = 16'h0003;
    #1;
    check("sv_data3", cpu_data, 16'h4444);
    step();
    check("sv_hits2", hit_count, 16'd5);

    // reset mid-fill
    cpu_addr = 16'h000C;
    step();
    check("rf_rd", 16'(mem_read), 16'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rf_rd0", 16'(mem_read), 16'd0);
    check("rf_maddr", mem_addr, 16'h0000);
    check("rf_hits", hit_count, 16'd0);
    check("rf_miss", miss_count, 16'd0);
    cpu_read  = 1'b0;
    mem_line  = make_line(16'h000C);
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    cpu_read  = 1'b1;
    #1;
    check("rf_ready", 16'(cpu_ready), 16'd0);
    step();
    check("rf_refill", 16'(mem_read), 16'd1);
    check("rf_raddr", mem_addr, 16'h000C);
    check("rf_miss1", miss_count, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
